mux2_rr_ctrl: RTL and testbench

Round-robin select controller and output register for the 8-bit 2:1 data mux.
- Arbitrates between two 8-bit valid/ready sources and drives the mux select `sel`.
- Registers the mux output `mux_y` into a single-entry output stage with valid/ready handshake.
- Keeps per-source accepted-transfer counters.
- Sits directly upstream of the mux on the select path and directly downstream of it on the data path.

---
 rtl/mux2_pkg.sv | 18 +
 rtl/mux2_rr_outreg.sv | 40 ++++
 rtl/mux2_rr_ctrl.sv | 149 ++++++++++++++
 tb/tb_mux2_rr_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux2_pkg.sv
// Shared definitions for the round-robin 2:1 mux controller: select encoding,
// default data width and the burst-mode FSM state type.
package mux2_pkg;

    // Select encoding for the 2:1 mux
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Default data width of the mux path
    localparam int unsigned DATA_W = 8;

    // Burst-mode arbitration states (only used when MUX2_RR_BURST_EN is defined)
    typedef enum logic {
        ALT,
        HOLD
    } burst_state_e;

endpackage

// File: rtl/mux2_rr_outreg.sv
// Single-entry valid/ready output register for the mux data path.
// Refills in the same cycle it drains, giving one transfer per clock.
module mux2_rr_outreg
    import mux2_pkg::*;
#(
    parameter int unsigned W = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         accept,
    input  logic         in_src,
    input  logic [W-1:0] in_data,
    input  logic         out_ready,
    output logic         load,
    output logic [W-1:0] out_data,
    output logic         out_src,
    output logic         out_valid
);

    // Register may take new data when empty or being drained this cycle
    always_comb begin
        load = !out_valid | out_ready;
    end

    // Capture on accept; clear valid on a drain with no refill; hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= SEL_A;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_src   <= in_src;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mux2_rr_ctrl.sv
// Round-robin select controller and output stage for the 8-bit 2:1 mux.
// Optional burst arbitration is enabled by defining MUX2_RR_BURST_EN.
module mux2_rr_ctrl
    import mux2_pkg::*;
#(
    parameter int unsigned W         = DATA_W,
    parameter int unsigned CW        = 8,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic          b_valid,
    output logic          b_ready,
    output logic          sel,
    input  logic [W-1:0]  mux_y,
    output logic [W-1:0]  out_data,
    output logic          out_src,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] cnt_a,
    output logic [CW-1:0] cnt_b
);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          last_q;
    logic          pick;
    logic          load;
    logic          accept;
    logic [CW-1:0] cnt_a_q;
    logic [CW-1:0] cnt_b_q;

`ifdef MUX2_RR_BURST_EN
    localparam int unsigned    BW        = $clog2(BURST_LEN + 1);
    localparam logic [BW-1:0]  BCNT_ONE  = BW'(1);
    localparam logic [BW-1:0]  BCNT_MAX  = BW'(BURST_LEN);

    burst_state_e  state_q, state_d;
    logic          hold_src_q, hold_src_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [BW-1:0] bcnt_inc;
    logic          hold_valid;
`else
    // Keeps the burst parameter referenced when the burst feature is compiled out
    logic unused_burst_len;
    assign unused_burst_len = ^BURST_LEN;
`endif

    // Arbitration: tie alternates, single requester wins, idle holds last select
    always_comb begin
        pick = last_q;
        case ({a_valid, b_valid})
            2'b11:   pick = ~last_q;
            2'b10:   pick = SEL_A;
            2'b01:   pick = SEL_B;
            default: pick = last_q;
        endcase
`ifdef MUX2_RR_BURST_EN
        if (state_q == HOLD && hold_valid && bcnt_q < BCNT_MAX) begin
            pick = hold_src_q;
        end
`endif
    end

    // Grant generation; readies are forced low while in reset
    always_comb begin
        sel     = pick;
        a_ready = !rst & load & a_valid & (pick == SEL_A);
        b_ready = !rst & load & b_valid & (pick == SEL_B);
        accept  = a_ready | b_ready;
        cnt_a   = cnt_a_q;
        cnt_b   = cnt_b_q;
    end

    // Last-granted source and per-source transfer counters (wrap silently)
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q  <= SEL_B;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            if (accept) begin
                last_q <= pick;
            end
            if (a_ready) begin
                cnt_a_q <= cnt_a_q + CNT_ONE;
            end
            if (b_ready) begin
                cnt_b_q <= cnt_b_q + CNT_ONE;
            end
        end
    end

`ifdef MUX2_RR_BURST_EN
    // Burst FSM next state: accepts extend or start a burst, which ends at the
    // length limit or when the held source drops on a load cycle
    always_comb begin
        state_d    = state_q;
        hold_src_d = hold_src_q;
        bcnt_d     = bcnt_q;
        hold_valid = (hold_src_q == SEL_B) ? b_valid : a_valid;
        bcnt_inc   = (state_q == HOLD && hold_src_q == pick) ? bcnt_q + BCNT_ONE : BCNT_ONE;
        if (accept) begin
            if (bcnt_inc >= BCNT_MAX) begin
                state_d = ALT;
                bcnt_d  = '0;
            end else begin
                state_d    = HOLD;
                hold_src_d = pick;
                bcnt_d     = bcnt_inc;
            end
        end else if (load && state_q == HOLD && !hold_valid) begin
            state_d = ALT;
            bcnt_d  = '0;
        end
    end

    // Burst FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ALT;
            hold_src_q <= SEL_A;
            bcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            hold_src_q <= hold_src_d;
            bcnt_q     <= bcnt_d;
        end
    end
`endif

    mux2_rr_outreg #(
        .W (W)
    ) u_outreg (
        .clk       (clk),
        .rst       (rst),
        .accept    (accept),
        .in_src    (pick),
        .in_data   (mux_y),
        .out_ready (out_ready),
        .load      (load),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid)
    );

endmodule

// File: tb/tb_mux2_rr_ctrl.sv
// Directed self-checking bench for mux2_rr_ctrl. The mux itself is modelled
// here so that mux_y follows sel.
module tb_mux2_rr_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, a_ready;
    logic          b_valid, b_ready;
    logic          sel;
    logic [W-1:0]  mux_y;
    logic [W-1:0]  out_data;
    logic          out_src;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] cnt_a, cnt_b;

    logic [W-1:0]  a_dat, b_dat;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // 2:1 data mux in front of the controller
    assign mux_y = sel ? b_dat : a_dat;

    mux2_rr_ctrl #(
        .W         (W),
        .CW        (CW),
        .BURST_LEN (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .sel       (sel),
        .mux_y     (mux_y),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0]  tie_src;
        logic [7:0]  exp_cnt_a_tie, exp_cnt_b_tie;
        logic        exp_rel_src;
        logic [7:0]  exp_rel_data, exp_rel_cnt_a, exp_rel_cnt_b;
`ifdef MUX2_RR_BURST_EN
        logic [6:0]  burst_src;
        tie_src       = 4'b1000;
        exp_cnt_a_tie = 8'd3;
        exp_cnt_b_tie = 8'd1;
        exp_rel_src   = 1'b0;
        exp_rel_data  = 8'hC2;
        exp_rel_cnt_a = 8'd5;
        exp_rel_cnt_b = 8'd1;
`else
        tie_src       = 4'b1010;
        exp_cnt_a_tie = 8'd2;
        exp_cnt_b_tie = 8'd2;
        exp_rel_src   = 1'b1;
        exp_rel_data  = 8'hD3;
        exp_rel_cnt_a = 8'd3;
        exp_rel_cnt_b = 8'd3;
`endif

        // Reset then idle
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
        a_dat = '0; b_dat = '0;
        tick();
        a_valid = 1'b1;
        #1;
        check("rst_a_ready", a_ready, 0);
        a_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_cnt_a", cnt_a, 0);
        check("rst_cnt_b", cnt_b, 0);
        check("rst_out_data", out_data, 0);
        check("idle_sel", sel, 1);
        check("idle_a_ready", a_ready, 0);
        check("idle_b_ready", b_ready, 0);
        tick();
        check("idle_sel_hold", sel, 1);

        // Single A transfer
        a_dat = 8'h07; a_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("single_a_ready", a_ready, 1);
        check("single_b_ready", b_ready, 0);
        check("single_sel", sel, 0);
        tick();
        a_valid = 1'b0;
        check("single_out_valid", out_valid, 1);
        check("single_out_data", out_data, 8'h07);
        check("single_out_src", out_src, 0);
        check("single_cnt_a", cnt_a, 1);
        tick();
        check("drain_out_valid", out_valid, 0);
        check("drain_out_data", out_data, 8'h07);

        // Reset mid-operation clears counters and restores last
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_cnt_a", cnt_a, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_sel", sel, 1);

        // Tie alternation
        a_dat = 8'h85; b_dat = 8'h25; a_valid = 1'b1; b_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("tie_sel", sel, tie_src[k]);
            tick();
            check("tie_out_src", out_src, tie_src[k]);
            check("tie_out_data", out_data, tie_src[k] ? 8'h25 : 8'h85);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        check("tie_cnt_a", cnt_a, exp_cnt_a_tie);
        check("tie_cnt_b", cnt_b, exp_cnt_b_tie);
        tick();

        // Backpressure
        a_dat = 8'hC1; a_valid = 1'b1;
        #1;
        check("bp_first_a_ready", a_ready, 1);
        tick();
        a_dat = 8'hC2; b_dat = 8'hD3; b_valid = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_a_ready", a_ready, 0);
            check("bp_b_ready", b_ready, 0);
            check("bp_out_data", out_data, 8'hC1);
            check("bp_out_valid", out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("rel_b_ready", b_ready, exp_rel_src);
        check("rel_a_ready", a_ready, !exp_rel_src);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        check("rel_out_data", out_data, exp_rel_data);
        check("rel_out_src", out_src, exp_rel_src);
        check("rel_cnt_a", cnt_a, exp_rel_cnt_a);
        check("rel_cnt_b", cnt_b, exp_rel_cnt_b);
        tick();

        // Counter wrap on B with A untouched
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_dat = 8'h11; a_valid = 1'b1;
        tick();
        a_valid = 1'b0; b_dat = 8'hBB; b_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (i == 254) check("wrap_cnt_b_255", cnt_b, 255);
        end
        b_valid = 1'b0;
        check("wrap_cnt_b", cnt_b, 0);
        check("wrap_cnt_a", cnt_a, 1);
        tick();

`ifdef MUX2_RR_BURST_EN
        // Burst arbitration with BURST_LEN = 3
        burst_src = 7'b0111000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_dat = 8'h85; b_dat = 8'h25; a_valid = 1'b1; b_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            check("burst_out_src", out_src, burst_src[k]);
        end
        // Reset in the middle of a B burst; next tie must go to A
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("burst_mid_src", out_src, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("burst_rst_sel", sel, 0);
        check("burst_rst_a_ready", a_ready, 1);
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
